// File: rtl/i2c_pkg.sv
// Shared constants for the I2C register slave: FSM encoding, ACK levels, R/W bit values.
package i2c_pkg;

   localparam logic [3:0] StIdle     = 4'd0;
   localparam logic [3:0] StAddr     = 4'd1;
   localparam logic [3:0] StAddrAck  = 4'd2;
   localparam logic [3:0] StPtr      = 4'd3;
   localparam logic [3:0] StPtrAck   = 4'd4;
   localparam logic [3:0] StWdata    = 4'd5;
   localparam logic [3:0] StWdataAck = 4'd6;
   localparam logic [3:0] StRdata    = 4'd7;
   localparam logic [3:0] StRdataAck = 4'd8;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_in_filter.sv
// Input conditioning for one I2C line: 2-FF synchronizer, FILT_LEN stability filter and
// edge detect on the filtered level.
module i2c_in_filter #(
   parameter int unsigned FILT_LEN = 3
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic in_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int unsigned CW = $clog2(FILT_LEN + 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Level changes only after FILT_LEN consecutive samples disagree with it.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(FILT_LEN - 1)) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
            fall_d  = ~sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= in_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target with a REG_NUM x 8-bit register file, pointer auto-increment and a local write port.
// Optional SCL-low bus timeout enabled by defining I2C_SLV_TIMEOUT_EN.
module i2c_slave_regs
   import i2c_pkg::*;
#(
   parameter logic [6:0]  SLAVE_ADDR  = 7'h48,
   parameter int unsigned REG_NUM     = 4,
   parameter int unsigned FILT_LEN    = 3,
   parameter logic [23:0] TIMEOUT_CYC = 24'd2_500_000
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic                   scl,
   inout  wire                    sda,
   input  logic                   usr_we,
   input  logic [7:0]             usr_addr,
   input  logic [7:0]             usr_wdata,
   output logic [8*REG_NUM-1:0]   regs_flat,
   output logic                   i2c_wr_pulse,
   output logic [7:0]             i2c_wr_addr,
   output logic                   busy
);

   localparam int unsigned PW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

   logic          scl_lvl, scl_rise, scl_fall;
   logic          sda_lvl, sda_rise, sda_fall;
   logic          start_det, stop_det, to_hit;

   logic [3:0]    state_q, state_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [PW-1:0] ptr_q, ptr_d, ptr_nxt;
   logic          drive_q, drive_d;
   logic          busy_q, busy_d;
   logic          rw_q, rw_d;
   logic          wr_pulse_q, wr_pulse_d;
   logic [7:0]    wr_addr_q, wr_addr_d;
   logic [7:0]    regs_q [REG_NUM];
   logic [7:0]    regs_d [REG_NUM];
   logic          i2c_we;
   logic [7:0]    byte_in;
   logic          unused_ok;

   i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
      .clk_i   (sys_clk),
      .rst_i   (sys_rst),
      .in_i    (scl),
      .level_o (scl_lvl),
      .rise_o  (scl_rise),
      .fall_o  (scl_fall)
   );

   i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
      .clk_i   (sys_clk),
      .rst_i   (sys_rst),
      .in_i    (sda),
      .level_o (sda_lvl),
      .rise_o  (sda_rise),
      .fall_o  (sda_fall)
   );

   assign start_det = sda_fall & scl_lvl;
   assign stop_det  = sda_rise & scl_lvl;
   assign byte_in   = {shift_q[6:0], sda_lvl};
   assign ptr_nxt   = ptr_q + PW'(1);

`ifdef I2C_SLV_TIMEOUT_EN
   logic [23:0] to_cnt_q, to_cnt_d;

   assign to_hit   = busy_q & ~scl_lvl & (to_cnt_q == TIMEOUT_CYC - 24'd1);
   assign to_cnt_d = (busy_q & ~scl_lvl & ~to_hit) ? to_cnt_q + 24'd1 : 24'd0;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) to_cnt_q <= '0;
      else         to_cnt_q <= to_cnt_d;
   end

   assign unused_ok = ^usr_addr;
`else
   assign to_hit    = 1'b0;
   assign unused_ok = ^{usr_addr, TIMEOUT_CYC};
`endif

   // bit_cnt 8 = byte done, ACK not yet driven; 9 = ninth clock sampled, act on next fall.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      ptr_d      = ptr_q;
      drive_d    = drive_q;
      busy_d     = busy_q;
      rw_d       = rw_q;
      wr_pulse_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      i2c_we     = 1'b0;

      if (start_det) begin
         state_d   = StAddr;
         busy_d    = 1'b1;
         bit_cnt_d = '0;
         drive_d   = 1'b0;
      end else if (stop_det || to_hit) begin
         state_d   = StIdle;
         busy_d    = 1'b0;
         bit_cnt_d = '0;
         drive_d   = 1'b0;
      end else begin
         case (state_q)
            StAddr, StPtr, StWdata: begin
               if (scl_rise) begin
                  shift_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     if (state_q == StAddr) begin
                        if (byte_in[7:1] == SLAVE_ADDR) begin
                           rw_d    = byte_in[0];
                           state_d = StAddrAck;
                        end else begin
                           state_d = StIdle;
                        end
                     end else if (state_q == StPtr) begin
                        ptr_d   = byte_in[PW-1:0];
                        state_d = StPtrAck;
                     end else begin
                        i2c_we     = 1'b1;
                        wr_pulse_d = 1'b1;
                        wr_addr_d  = 8'(ptr_q);
                        ptr_d      = ptr_nxt;
                        state_d    = StWdataAck;
                     end
                  end
               end
            end
            StAddrAck, StPtrAck, StWdataAck: begin
               if (scl_rise && bit_cnt_q == 4'd8) begin
                  bit_cnt_d = 4'd9;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  drive_d = ~I2C_ACK;
               end else if (scl_fall && bit_cnt_q == 4'd9) begin
                  drive_d   = 1'b0;
                  bit_cnt_d = '0;
                  if (state_q == StAddrAck && rw_q == RW_READ) begin
                     shift_d = regs_q[ptr_q];
                     drive_d = ~regs_q[ptr_q][7];
                     state_d = StRdata;
                  end else if (state_q == StAddrAck) begin
                     state_d = StPtr;
                  end else begin
                     state_d = StWdata;
                  end
               end
            end
            StRdata: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     drive_d   = 1'b0;
                     bit_cnt_d = '0;
                     state_d   = StRdataAck;
                  end else begin
                     shift_d = {shift_q[6:0], 1'b0};
                     drive_d = ~shift_q[6];
                  end
               end
            end
            StRdataAck: begin
               if (scl_rise && bit_cnt_q == 4'd0) begin
                  if (sda_lvl == I2C_ACK) begin
                     ptr_d     = ptr_nxt;
                     shift_d   = regs_q[ptr_nxt];
                     bit_cnt_d = 4'd9;
                  end else begin
                     state_d = StIdle;
                  end
               end else if (scl_fall && bit_cnt_q == 4'd9) begin
                  drive_d   = ~shift_q[7];
                  bit_cnt_d = '0;
                  state_d   = StRdata;
               end
            end
            default: begin
               drive_d = 1'b0;
            end
         endcase
      end

      // I2C write applied last so it wins a same-register collision.
      regs_d = regs_q;
      if (usr_we) regs_d[usr_addr[PW-1:0]] = usr_wdata;
      if (i2c_we) regs_d[ptr_q] = byte_in;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         ptr_q      <= '0;
         drive_q    <= 1'b0;
         busy_q     <= 1'b0;
         rw_q       <= RW_WRITE;
         wr_pulse_q <= 1'b0;
         wr_addr_q  <= '0;
         for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         ptr_q      <= ptr_d;
         drive_q    <= drive_d;
         busy_q     <= busy_d;
         rw_q       <= rw_d;
         wr_pulse_q <= wr_pulse_d;
         wr_addr_q  <= wr_addr_d;
         for (int i = 0; i < REG_NUM; i++) regs_q[i] <= regs_d[i];
      end
   end

   for (genvar i = 0; i < REG_NUM; i++) begin : g_flat
      assign regs_flat[8*i +: 8] = regs_q[i];
   end

   assign sda          = drive_q ? 1'b0 : 1'bz;
   assign busy         = busy_q;
   assign i2c_wr_pulse = wr_pulse_q;
   assign i2c_wr_addr  = wr_addr_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: bit-banged I2C master, hand-computed register expectations.
module tb_i2c_slave_regs;

   localparam int Q = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        scl_m = 1'b1;
   logic        sda_m = 1'b1;
   logic        usr_we = 1'b0;
   logic [7:0]  usr_addr = '0;
   logic [7:0]  usr_wdata = '0;
   wire         sda;
   logic [31:0] regs_flat;
   logic        wr_pulse;
   logic [7:0]  wr_addr;
   logic        busy;

   int          total = 0;
   int          bad = 0;
   int          pulse_cnt = 0;
   int          slv_low = 0;
   logic [7:0]  last_addr = '0;
   logic        ack;
   logic        s;
   logic [7:0]  rd;
   int          p0;

   assign sda = sda_m ? 1'bz : 1'b0;
   pullup (sda);

   always #5 clk = ~clk;

   i2c_slave_regs #(
      .SLAVE_ADDR  (7'h48),
      .REG_NUM     (4),
      .FILT_LEN    (3),
      .TIMEOUT_CYC (24'd200)
   ) dut (
      .sys_clk      (clk),
      .sys_rst      (rst),
      .scl          (scl_m),
      .sda          (sda),
      .usr_we       (usr_we),
      .usr_addr     (usr_addr),
      .usr_wdata    (usr_wdata),
      .regs_flat    (regs_flat),
      .i2c_wr_pulse (wr_pulse),
      .i2c_wr_addr  (wr_addr),
      .busy         (busy)
   );

   always @(negedge clk) begin
      if (wr_pulse) begin
         pulse_cnt++;
         last_addr = wr_addr;
      end
      if (sda_m && sda === 1'b0) slv_low++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_q(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wait_q(Q);
      scl_m = 1'b1; wait_q(Q);
      sda_m = 1'b0; wait_q(Q);
      scl_m = 1'b0; wait_q(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wait_q(Q);
      scl_m = 1'b1; wait_q(Q);
      sda_m = 1'b1; wait_q(2 * Q);
   endtask

   task automatic bit_io(input logic b, output logic smp);
      sda_m = b;    wait_q(Q);
      scl_m = 1'b1; wait_q(Q);
      smp = (sda === 1'b0) ? 1'b0 : 1'b1;
      wait_q(Q);
      scl_m = 1'b0; wait_q(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic acked);
      logic x;
      for (int i = 7; i >= 0; i--) bit_io(b[i], x);
      bit_io(1'b1, x);
      acked = ~x;
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic x;
      for (int i = 7; i >= 0; i--) begin
         bit_io(1'b1, x);
         d[i] = x;
      end
      bit_io(mack, x);
   endtask

   function automatic logic [7:0] reg_at(input int i);
      return regs_flat[8*i +: 8];
   endfunction

   // Holds a local write active until the I2C write pulse shows up, so both land in one cycle.
   task automatic usr_window(input logic [7:0] a, input logic [7:0] d);
      logic hit;
      hit = 1'b0;
      @(negedge clk);
      usr_addr = a; usr_wdata = d; usr_we = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (wr_pulse) begin
            hit = 1'b1;
            break;
         end
      end
      usr_we = 1'b0;
      check_eq("usr_window_pulse_seen", 32'(hit), 32'd1);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      wait_q(5);
      @(negedge clk) rst = 1'b0;
      wait_q(5);
      @(negedge clk);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_regs", regs_flat, 32'h0);
      check_eq("rst_pulse", 32'(wr_pulse), 32'd0);
      check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
      check_eq("rst_sda", 32'(sda === 1'b0 ? 0 : 1), 32'd1);

      // Plain write of 0xA5 to reg1
      i2c_start();
      @(negedge clk) check_eq("t1_busy_after_start", 32'(busy), 32'd1);
      write_byte(8'h90, ack); check_eq("t1_ack_addr", 32'(ack), 32'd1);
      write_byte(8'h01, ack); check_eq("t1_ack_ptr", 32'(ack), 32'd1);
      write_byte(8'hA5, ack); check_eq("t1_ack_data", 32'(ack), 32'd1);
      i2c_stop();
      @(negedge clk);
      check_eq("t1_reg1", 32'(reg_at(1)), 32'hA5);
      check_eq("t1_pulses", pulse_cnt, 1);
      check_eq("t1_wr_addr", 32'(last_addr), 32'd1);
      check_eq("t1_busy_after_stop", 32'(busy), 32'd0);

      // reg2 = 0x3C, then pointer write + repeated START read
      i2c_start();
      write_byte(8'h90, ack);
      write_byte(8'h02, ack);
      write_byte(8'h3C, ack);
      i2c_stop();
      i2c_start();
      write_byte(8'h90, ack); check_eq("t2_ack_90", 32'(ack), 32'd1);
      write_byte(8'h02, ack); check_eq("t2_ack_02", 32'(ack), 32'd1);
      i2c_start();
      write_byte(8'h91, ack); check_eq("t2_ack_91", 32'(ack), 32'd1);
      read_byte(1'b1, rd);    check_eq("t2_read_reg2", 32'(rd), 32'h3C);
      wait_q(Q);
      check_eq("t2_sda_released", 32'(sda === 1'b0 ? 0 : 1), 32'd1);
      i2c_stop();

      // Two-byte read with master ACK in between: reg1 then reg2
      i2c_start();
      write_byte(8'h90, ack);
      write_byte(8'h01, ack);
      i2c_start();
      write_byte(8'h91, ack);
      read_byte(1'b0, rd); check_eq("t2_burst_b0", 32'(rd), 32'hA5);
      read_byte(1'b1, rd); check_eq("t2_burst_b1", 32'(rd), 32'h3C);
      i2c_stop();

      // Wrong address: never driven, busy held until STOP
      slv_low = 0;
      p0 = pulse_cnt;
      i2c_start();
      write_byte(8'h92, ack); check_eq("t3_no_ack", 32'(ack), 32'd0);
      write_byte(8'h00, ack);
      @(negedge clk) check_eq("t3_busy_held", 32'(busy), 32'd1);
      check_eq("t3_sda_never_low", slv_low, 0);
      i2c_stop();
      @(negedge clk);
      check_eq("t3_regs_unchanged", regs_flat, 32'h003C_A500);
      check_eq("t3_busy_after_stop", 32'(busy), 32'd0);
      check_eq("t3_no_pulse", pulse_cnt, p0);

      // Pointer wrap 3 -> 0
      i2c_start();
      write_byte(8'h90, ack);
      write_byte(8'h03, ack);
      write_byte(8'h11, ack);
      write_byte(8'h22, ack);
      i2c_stop();
      @(negedge clk);
      check_eq("t4_reg3", 32'(reg_at(3)), 32'h11);
      check_eq("t4_reg0", 32'(reg_at(0)), 32'h22);
      check_eq("t4_last_addr", 32'(last_addr), 32'd0);

      // STOP after 5 data bits aborts the byte
      p0 = pulse_cnt;
      i2c_start();
      write_byte(8'h90, ack);
      write_byte(8'h00, ack);
      for (int i = 0; i < 5; i++) bit_io(1'b1, s);
      i2c_stop();
      @(negedge clk);
      check_eq("t5_reg0_kept", 32'(reg_at(0)), 32'h22);
      check_eq("t5_no_pulse", pulse_cnt, p0);

      // Local write with index 6 (mod 4 = 2); pointer must stay at 0
      @(negedge clk) begin usr_addr = 8'h06; usr_wdata = 8'h5E; usr_we = 1'b1; end
      @(negedge clk) usr_we = 1'b0;
      check_eq("t5_usr_reg2", 32'(reg_at(2)), 32'h5E);

      // Read from pointer 0, then reset while driving bit 6 of reg1 (0)
      i2c_start();
      write_byte(8'h91, ack);
      read_byte(1'b0, rd); check_eq("t5_read_ptr0", 32'(rd), 32'h22);
      bit_io(1'b1, s);     check_eq("t5_rd_bit7", 32'(s), 32'd1);
      @(negedge clk) check_eq("t5_slave_driving", 32'(sda === 1'b0 ? 1 : 0), 32'd1);
      rst = 1'b1;
      #1;
      check_eq("t5_rst_sda", 32'(sda === 1'b0 ? 0 : 1), 32'd1);
      check_eq("t5_rst_busy", 32'(busy), 32'd0);
      scl_m = 1'b1; sda_m = 1'b1;
      wait_q(3);
      @(negedge clk) rst = 1'b0;
      wait_q(10);
      check_eq("t5_rst_regs", regs_flat, 32'h0);

      // Same-register collision: I2C wins. Different registers: both land.
      i2c_start();
      write_byte(8'h90, ack);
      write_byte(8'h01, ack);
      fork
         write_byte(8'h77, ack);
         usr_window(8'h01, 8'h33);
      join
      fork
         write_byte(8'h88, ack);
         usr_window(8'h00, 8'h55);
      join
      i2c_stop();
      @(negedge clk);
      check_eq("t6_collide_reg1", 32'(reg_at(1)), 32'h77);
      check_eq("t6_reg2", 32'(reg_at(2)), 32'h88);
      check_eq("t6_usr_reg0", 32'(reg_at(0)), 32'h55);

`ifdef I2C_SLV_TIMEOUT_EN
      i2c_start();
      write_byte(8'h90, ack);
      wait_q(300);
      @(negedge clk);
      check_eq("t7_timeout_busy", 32'(busy), 32'd0);
      check_eq("t7_timeout_sda", 32'(sda === 1'b0 ? 0 : 1), 32'd1);
      sda_m = 1'b1;
      scl_m = 1'b1;
      wait_q(Q);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C target (responder) end of the on-board I2C bus. It is used as a register-mapped peripheral model and as a loopback partner for the I2C master driver.
- Answers the PCF8591-style protocol: one device address byte, one pointer byte, then data bytes with pointer auto-increment.
- Holds a REG_NUM x 8-bit register file. I2C can write it, and a local user port can also write it.
- Bus side is SCL input and open-drain SDA. No clock stretching.

Parameters:
- SLAVE_ADDR, 7'h48, 7-bit device address this block answers to.
- REG_NUM, 4, number of 8-bit registers; must be a power of two, 2..256.
- FILT_LEN, 3, number of consecutive equal samples required before a filtered SCL/SDA level changes.
- TIMEOUT_CYC, 24'd2_500_000, SCL-low cycle count before bus reset (only used with the optional feature).

Ports:
- sys_clk  in  1  system clock, at least 20x the SCL rate.
- sys_rst  in  1  asynchronous reset, active-high.
- scl  in  1  I2C clock from the master.
- sda  inout  1  I2C data; driven 0 or released to Z.
- usr_we  in  1  local write strobe, single cycle.
- usr_addr  in  8  local register index, taken modulo REG_NUM.
- usr_wdata  in  8  local write data.
- regs_flat  out  8*REG_NUM  register file contents; reg i sits at bits [8i+7:8i].
- i2c_wr_pulse  out  1  one-cycle pulse on each register written over I2C.
- i2c_wr_addr  out  8  index of the register just written over I2C.
- busy  out  1  high from START to STOP.

Behaviour:
- Reset: all registers 0, pointer 0, SDA released, i2c_wr_pulse=0, i2c_wr_addr=0, busy=0, FSM in IDLE. Reset mid-transfer releases SDA immediately.
- Input conditioning: 2-FF synchronizer on SCL and SDA, then the FILT_LEN stability filter. Rise and fall edges are taken from the filtered SCL.
- START: filtered SDA falls while SCL is high. Enter ADDR, set busy=1, clear bit counter. A repeated START is legal in any state.
- STOP: filtered SDA rises while SCL is high. Go to IDLE, release SDA, set busy=0. STOP in any state aborts the byte in progress with no register write.
- Bits are sampled on the SCL rising edge, MSB first. SDA drive changes only in the cycle after an SCL falling edge is detected.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- ADDR: after 8 bits, if addr[7:1]==SLAVE_ADDR, drive ACK (SDA=0) for the 9th clock. Otherwise go to IDLE with SDA released, and busy stays 1 until STOP.
- ADDR_ACK → PTR if R/W=0; → RDATA if R/W=1, with reg[pointer] loaded into the shift register.
- PTR: 8 bits → pointer = byte mod REG_NUM; ACK; → WDATA.
- WDATA: after 8 bits, write reg[pointer], pulse i2c_wr_pulse with i2c_wr_addr=pointer, ACK, increment pointer modulo REG_NUM (wraps REG_NUM-1 → 0); → WDATA.
- RDATA: drive shift-register bits (1 = release) for 8 clocks, then release SDA for the master's ACK.
- RDATA_ACK: on the 9th rising edge, SDA=0 (ACK) → increment pointer, load the next register, → RDATA. SDA=1 (NACK) → IDLE until STOP or repeated START.
- Collision: an I2C write and usr_we to the same register in the same cycle resolve to the I2C write. Different registers are both written. usr_we does not alter the pointer.
- Pointer persists across transactions (read-after-pointer-write through repeated START).

Optional Feature:
- I2C_SLV_TIMEOUT_EN defined: a counter runs while busy=1 and filtered SCL is low. When it reaches TIMEOUT_CYC, the FSM goes to IDLE, SDA is released and busy goes to 0.
- Not defined: no counter; the FSM waits indefinitely for the master.

Decomposition:
- Package i2c_pkg: FSM state encoding, ACK/NACK constants, R/W bit constants.
- One sub-module, i2c_in_filter: synchronizer + stability filter + edge detect. Instantiated once per line, outputs level, rise and fall.

Test Plan:
- Write 0x90, 0x01, 0xA5, STOP → three ACKs, reg1=0xA5, one i2c_wr_pulse with i2c_wr_addr=1.
- Write 0x90, 0x02, then repeated START, 0x91, read one byte, NACK → ACKs on 0x90/0x02/0x91, read byte equals reg2, SDA released after NACK.
- Address byte 0x92 → SDA never driven low, registers unchanged, busy=1 until STOP.
- REG_NUM=4: write 0x90, 0x03, 0x11, 0x22 → reg3=0x11, reg0=0x22 (pointer wrap).
- STOP after 5 data bits, and sys_rst asserted mid-RDATA → no register write; SDA released, busy=0 within 1 cycle of reset.
- usr_we with addr 1 in the same cycle as an I2C write to reg1 → reg1 holds the I2C value. With I2C_SLV_TIMEOUT_EN, hold SCL low for TIMEOUT_CYC → busy=0.
